// File: rtl/isa_arb_pkg.sv
// rtl/isa_arb_pkg.sv - shared types and constants for the ISA bus arbiter
package isa_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam int          CMD_READ_BIT     = 0;
    localparam int          CMD_WRITE_BIT    = 1;
    localparam logic [7:0]  RDATA_ON_TIMEOUT = 8'hFF;

    function automatic logic [1:0] cmd_for(input logic we);
        logic [1:0] c;
        c = '0;
        c[we ? CMD_WRITE_BIT : CMD_READ_BIT] = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/isa_arb_rr_pick.sv
// rtl/isa_arb_rr_pick.sv - combinational two-way round-robin winner select
module isa_arb_rr_pick (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid  = |req;
        winner = 1'b0;
        if (req == 2'b11) begin
            winner = ~last_grant;
        end else if (req[1]) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/isa_bus_arbiter.sv
// rtl/isa_bus_arbiter.sv - round-robin front end for the ISA bus-cycle sequencer
// Optional RUN-state abort timer enabled by defining ISA_ARB_TIMEOUT_EN.
module isa_bus_arbiter
    import isa_arb_pkg::*;
#(
    parameter int ADDR_W         = 10,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TIMEOUT_W      = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [7:0]        r0_wdata,
    output logic              r0_ack,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [7:0]        r1_wdata,
    output logic              r1_ack,
    output logic [7:0]        rd_data,
    output logic              err,
    output logic              busy,
    output logic              grant_id,
    output logic [1:0]        seq_cmd,
    output logic [ADDR_W-1:0] seq_addr,
    output logic [7:0]        seq_wdata,
    input  logic [7:0]        seq_rdata,
    input  logic              seq_data_read_n,
    input  logic              seq_done_n
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES >= (1 << TIMEOUT_W)) begin : g_bad_timeout
        $error("TIMEOUT_W too narrow for TIMEOUT_CYCLES");
    end

    state_t            state, state_n;
    logic              last_grant, last_grant_n;
    logic [1:0]        seq_cmd_n;
    logic [ADDR_W-1:0] seq_addr_n;
    logic [7:0]        seq_wdata_n, rd_data_n;
    logic              r0_ack_n, r1_ack_n, busy_n, grant_id_n, err_n;
    logic              pick_valid, pick;

    isa_arb_rr_pick u_pick (
        .req        ({r1_req, r0_req}),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .winner     (pick)
    );

`ifdef ISA_ARB_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    logic [TIMEOUT_W-1:0] to_cnt, to_cnt_n;
`endif

    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        seq_cmd_n    = seq_cmd;
        seq_addr_n   = seq_addr;
        seq_wdata_n  = seq_wdata;
        rd_data_n    = rd_data;
        grant_id_n   = grant_id;
        busy_n       = busy;
        r0_ack_n     = 1'b0;
        r1_ack_n     = 1'b0;
        err_n        = 1'b0;
`ifdef ISA_ARB_TIMEOUT_EN
        to_cnt_n     = to_cnt;
`endif
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_n     = ST_RUN;
                    grant_id_n  = pick;
                    seq_cmd_n   = cmd_for(pick ? r1_we : r0_we);
                    seq_addr_n  = pick ? r1_addr : r0_addr;
                    seq_wdata_n = pick ? r1_wdata : r0_wdata;
                    busy_n      = 1'b1;
`ifdef ISA_ARB_TIMEOUT_EN
                    to_cnt_n    = '0;
`endif
                end
            end
            ST_RUN: begin
                if (!seq_data_read_n && seq_cmd[CMD_READ_BIT]) begin
                    rd_data_n = seq_rdata;
                end
                // Command drops on the done edge so the sequencer idles with no command pending.
                if (!seq_done_n) begin
                    seq_cmd_n = '0;
                    state_n   = ST_ACK;
                    r0_ack_n  = ~grant_id;
                    r1_ack_n  = grant_id;
`ifdef ISA_ARB_TIMEOUT_EN
                end else if (to_cnt == TO_LAST) begin
                    seq_cmd_n = '0;
                    rd_data_n = RDATA_ON_TIMEOUT;
                    err_n     = 1'b1;
                    state_n   = ST_ACK;
                    r0_ack_n  = ~grant_id;
                    r1_ack_n  = grant_id;
                end else begin
                    to_cnt_n  = to_cnt + 1'b1;
`endif
                end
            end
            ST_ACK: begin
                last_grant_n = grant_id;
                busy_n       = 1'b0;
                state_n      = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            seq_cmd    <= '0;
            seq_addr   <= '0;
            seq_wdata  <= '0;
            rd_data    <= '0;
            grant_id   <= 1'b0;
            busy       <= 1'b0;
            r0_ack     <= 1'b0;
            r1_ack     <= 1'b0;
        end else begin
            state      <= state_n;
            last_grant <= last_grant_n;
            seq_cmd    <= seq_cmd_n;
            seq_addr   <= seq_addr_n;
            seq_wdata  <= seq_wdata_n;
            rd_data    <= rd_data_n;
            grant_id   <= grant_id_n;
            busy       <= busy_n;
            r0_ack     <= r0_ack_n;
            r1_ack     <= r1_ack_n;
        end
    end

`ifdef ISA_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err    <= 1'b0;
            to_cnt <= '0;
        end else begin
            err    <= err_n;
            to_cnt <= to_cnt_n;
        end
    end
`else
    assign err = 1'b0;
    logic unused_err_n;
    assign unused_err_n = err_n;
`endif

endmodule

// File: tb/tb_isa_bus_arbiter.sv
// tb/tb_isa_bus_arbiter.sv - directed self-checking bench with behavioural sequencer model
`timescale 1ns/1ps
module tb_isa_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       r0_req, r0_we, r1_req, r1_we;
    logic [9:0] r0_addr, r1_addr;
    logic [7:0] r0_wdata, r1_wdata;
    logic       r0_ack, r1_ack, err, busy, grant_id;
    logic [7:0] rd_data, seq_wdata, seq_rdata;
    logic [1:0] seq_cmd;
    logic [9:0] seq_addr;
    logic       seq_data_read_n, seq_done_n;

    int checks = 0;
    int errors = 0;

    logic [7:0] seq_cnt;
    logic [7:0] model_data;
    logic       hang;

    always #5 clk = ~clk;

    // Sequencer model: capture strobe on the 5th command clock, done on the 6th.
    always_ff @(posedge clk) begin
        if (seq_cmd == 2'b00) seq_cnt <= 8'd0;
        else if (seq_cnt != 8'hFF) seq_cnt <= seq_cnt + 8'd1;
    end
    assign seq_data_read_n = !(seq_cmd != 2'b00 && seq_cnt == 8'd4);
    assign seq_done_n      = !(!hang && seq_cmd != 2'b00 && seq_cnt == 8'd5);
    assign seq_rdata       = (seq_cnt == 8'd4) ? model_data : 8'h00;

    isa_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_ack(r0_ack),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_ack(r1_ack),
        .rd_data(rd_data), .err(err), .busy(busy), .grant_id(grant_id),
        .seq_cmd(seq_cmd), .seq_addr(seq_addr), .seq_wdata(seq_wdata),
        .seq_rdata(seq_rdata), .seq_data_read_n(seq_data_read_n), .seq_done_n(seq_done_n)
    );

    task automatic wait_ack(input int limit, output int n);
        n = 0;
        while (n < limit && !(r0_ack || r1_ack)) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; r0_req = 1'b0; r1_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; r0_req = 0; r1_req = 0; r0_we = 0; r1_we = 0;
        r0_addr = '0; r1_addr = '0; r0_wdata = '0; r1_wdata = '0;
        hang = 1'b0; model_data = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({seq_cmd, seq_addr, seq_wdata, rd_data} !== 28'h0 ||
            {r0_ack, r1_ack, err, busy, grant_id} !== 5'b0) begin
            errors++;
            $display("FAIL reset_state: cmd=%b addr=%h wd=%h rd=%h ack=%b%b err=%b busy=%b gid=%b, required all zero",
                     seq_cmd, seq_addr, seq_wdata, rd_data, r0_ack, r1_ack, err, busy, grant_id);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        int n;
        r0_req = 1; r0_we = 1; r0_addr = 10'h220; r0_wdata = 8'h5A;
        @(negedge clk);
        checks++;
        if (seq_cmd !== 2'b10 || seq_addr !== 10'h220 || seq_wdata !== 8'h5A || busy !== 1'b1 || grant_id !== 1'b0) begin
            errors++;
            $display("FAIL write_grant: cmd=%b addr=%h wd=%h busy=%b gid=%b, required 10/220/5a/1/0",
                     seq_cmd, seq_addr, seq_wdata, busy, grant_id);
        end
        wait_ack(20, n);
        checks++;
        if (n !== 6) begin errors++; $display("FAIL write_latency: %0d cycles, required 6", n); end
        checks++;
        if (r0_ack !== 1'b1 || r1_ack !== 1'b0 || seq_cmd !== 2'b00 || err !== 1'b0) begin
            errors++;
            $display("FAIL write_ack: ack=%b%b cmd=%b err=%b, required ack r0 only, cmd 00, err 0", r0_ack, r1_ack, seq_cmd, err);
        end
        checks++;
        if (rd_data !== 8'h00) begin errors++; $display("FAIL write_rd_data: %h, required 00", rd_data); end
        r0_req = 0;
        @(negedge clk);
        checks++;
        if (r0_ack !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL write_ack_pulse: ack=%b busy=%b, required 0 0", r0_ack, busy);
        end
    endtask

    task automatic test_read();
        int n;
        model_data = 8'hC3;
        r1_req = 1; r1_we = 0; r1_addr = 10'h388;
        @(negedge clk);
        checks++;
        if (seq_cmd !== 2'b01 || seq_addr !== 10'h388 || grant_id !== 1'b1) begin
            errors++;
            $display("FAIL read_grant: cmd=%b addr=%h gid=%b, required 01/388/1", seq_cmd, seq_addr, grant_id);
        end
        wait_ack(20, n);
        checks++;
        if (n !== 6 || r1_ack !== 1'b1 || r0_ack !== 1'b0 || rd_data !== 8'hC3 || err !== 1'b0 || grant_id !== 1'b1) begin
            errors++;
            $display("FAIL read_ack: n=%0d ack=%b%b rd=%h err=%b gid=%b, required 6/01/c3/0/1",
                     n, r0_ack, r1_ack, rd_data, err, grant_id);
        end
        r1_req = 0;
        @(negedge clk);
        checks++;
        if (r1_ack !== 1'b0 || busy !== 1'b0 || rd_data !== 8'hC3) begin
            errors++;
            $display("FAIL read_after: ack=%b busy=%b rd=%h, required 0/0/c3", r1_ack, busy, rd_data);
        end
    endtask

    task automatic test_round_robin();
        int n;
        do_reset();
        r0_we = 1; r0_addr = 10'h100; r0_wdata = 8'h11;
        r1_we = 0; r1_addr = 10'h200; model_data = 8'h77;
        r0_req = 1; r1_req = 1;
        for (int i = 0; i < 4; i++) begin
            wait_ack(30, n);
            checks++;
            if (n >= 30 || {r1_ack, r0_ack} !== ((i % 2 == 0) ? 2'b01 : 2'b10) || grant_id !== 1'(i % 2)) begin
                errors++;
                $display("FAIL rr_order_%0d: n=%0d ack(r1,r0)=%b%b gid=%b, required gid %0d", i, n, r1_ack, r0_ack, grant_id, i % 2);
            end
            if (i == 3) begin r0_req = 0; r1_req = 0; end
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_in_run();
        int n;
        r0_req = 1; r0_we = 1; r0_addr = 10'h300; r0_wdata = 8'hA5;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (seq_cmd !== 2'b00 || busy !== 1'b0 || r0_ack !== 1'b0 || r1_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_run: cmd=%b busy=%b ack=%b%b, required 00/0/00", seq_cmd, busy, r0_ack, r1_ack);
        end
        r0_req = 0; reset = 1'b0;
        repeat (2) @(negedge clk);
        model_data = 8'h3C;
        r0_req = 1; r0_we = 0; r0_addr = 10'h2F8;
        @(negedge clk);
        checks++;
        if (seq_cmd !== 2'b01 || grant_id !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_grant: cmd=%b gid=%b, required 01/0", seq_cmd, grant_id);
        end
        wait_ack(20, n);
        checks++;
        if (n !== 6 || r0_ack !== 1'b1 || rd_data !== 8'h3C) begin
            errors++;
            $display("FAIL post_reset_read: n=%0d ack=%b rd=%h, required 6/1/3c", n, r0_ack, rd_data);
        end
        r0_req = 0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int n;
        hang = 1'b1;
        r0_req = 1; r0_we = 0; r0_addr = 10'h3F8;
        @(negedge clk);
`ifdef ISA_ARB_TIMEOUT_EN
        wait_ack(100, n);
        checks++;
        if (n !== 64 || r0_ack !== 1'b1 || err !== 1'b1 || rd_data !== 8'hFF || seq_cmd !== 2'b00) begin
            errors++;
            $display("FAIL timeout_abort: n=%0d ack=%b err=%b rd=%h cmd=%b, required 64/1/1/ff/00",
                     n, r0_ack, err, rd_data, seq_cmd);
        end
        r0_req = 0;
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err_pulse: err=%b busy=%b, required 0/0", err, busy);
        end
`else
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy !== 1'b1 || r0_ack !== 1'b0 || err !== 1'b0) n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL no_timeout_wait: %0d cycles not busy or acked, required 0", n);
        end
`endif
        hang = 1'b0;
        do_reset();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_reset_in_run();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
